// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-lane data memory with RISC-V load/store decode
// and a single-entry valid/ready response register.
module dmem_lsu #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              resp_err,
    output logic [1:0]        resp_cause
);
    localparam int B   = DWIDTH / 8;
    localparam int OB  = $clog2(B);
    localparam int AW  = $clog2(DEPTH);
    localparam bit W64 = (DWIDTH == 64);

    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_nx;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic              acc;
    logic [1:0]        size;
    logic [OB-1:0]     off;
    logic [AW-1:0]     widx;
    logic              legal, mis, oor, fault, wr_en;
    logic [1:0]        cause;
    logic [B-1:0]      be, be_sh;
    logic [DWIDTH-1:0] wsh, rsh, mask, ext;
    logic              sbit;

    assign acc  = req_valid && req_ready;
    assign size = req_funct3[1:0];
    assign off  = req_addr[OB-1:0];
    assign widx = req_addr[OB +: AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_valid)  state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    always_comb begin
        legal = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b011:                 legal = W64;
            3'b100, 3'b101:         legal = !req_we;
            3'b110:                 legal = !req_we && W64;
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        mis = 1'b0;
        unique case (size)
            2'b01:   mis = req_addr[0];
            2'b10:   mis = |req_addr[1:0];
            2'b11:   mis = |req_addr[2:0];
            default: mis = 1'b0;
        endcase
    end

    // full 32-bit index compare so high address bits cannot alias into range
    assign oor = (req_addr >> OB) >= 32'(DEPTH);

    always_comb begin
        if (!legal)   cause = 2'b11;
        else if (mis) cause = 2'b01;
        else if (oor) cause = 2'b10;
        else          cause = 2'b00;
    end

    assign fault = (cause != 2'b00);
    assign wr_en = acc && req_we && !fault;

    always_comb begin
        mask = '1;
        be   = '1;
        sbit = rsh[DWIDTH-1];
        unique case (size)
            2'b00: begin
                mask = DWIDTH'(8'hff);
                be   = B'(1);
                sbit = rsh[7];
            end
            2'b01: begin
                mask = DWIDTH'(16'hffff);
                be   = B'(3);
                sbit = rsh[15];
            end
            2'b10: begin
                mask = DWIDTH'(32'hffff_ffff);
                be   = B'(15);
                sbit = rsh[31];
            end
            default: ;
        endcase
    end

    assign be_sh = be << off;
    assign wsh   = req_wdata << {off, 3'b000};
    assign rsh   = mem[widx] >> {off, 3'b000};
    assign ext   = (rsh & mask) | ((sbit && !req_funct3[2]) ? ~mask : '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < B; i++) begin
                if (be_sh[i]) mem[widx][i*8 +: 8] <= wsh[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_cause <= 2'b00;
        end else if (acc) begin
            resp_rdata <= (fault || req_we) ? '0 : ext;
            resp_err   <= fault;
            resp_cause <= cause;
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu at DWIDTH=32, DEPTH=1024.
// Expected responses are queued at issue and checked when handed over.
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_cause;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    dmem_lsu #(.DWIDTH(32), .DEPTH(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_cause (resp_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rdata", resp_rdata, e.rdata);
                chk("err", 32'(resp_err), 32'(e.err));
                chk("cause", 32'(resp_cause), 32'(e.cause));
            end
        end
    end

    // called at posedge+1 with the DUT idle
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee,
                         input logic [1:0] ec, input bit wt);
        exp_t e;
        int   n;
        e.rdata = er;
        e.err   = ee;
        e.cause = ec;
        q.push_back(e);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (wt) begin
            n = 0;
            while (!resp_valid && n < 8) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("resp_seen", 32'(resp_valid), 32'd1);
            while (resp_valid && n < 16) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("resp_done", 32'(resp_valid), 32'd0);
        end
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] er, input logic [1:0] ec);
        issue(1'b0, f3, addr, 32'h0, er, ec != 2'b00, ec, 1'b1);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [1:0] ec);
        issue(1'b1, f3, addr, wd, 32'h0, ec != 2'b00, ec, 1'b1);
    endtask

    logic [7:0]  b [4];
    logic [31:0] w;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_cause", 32'(resp_cause), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        st(3'b010, 32'h10, 32'h80FF7F01, 2'b00);
        ld(3'b000, 32'h10, 32'h00000001, 2'b00);
        ld(3'b000, 32'h13, 32'hFFFFFF80, 2'b00);
        ld(3'b100, 32'h13, 32'h00000080, 2'b00);
        ld(3'b001, 32'h12, 32'hFFFF80FF, 2'b00);
        ld(3'b101, 32'h12, 32'h000080FF, 2'b00);
        ld(3'b010, 32'h10, 32'h80FF7F01, 2'b00);
        st(3'b000, 32'h11, 32'h123456AA, 2'b00);
        ld(3'b010, 32'h10, 32'h80FFAA01, 2'b00);
        st(3'b001, 32'h12, 32'h5555BEEF, 2'b00);
        ld(3'b010, 32'h10, 32'hBEEFAA01, 2'b00);

        ld(3'b001, 32'h13, 32'h0, 2'b01);
        st(3'b010, 32'h12, 32'hDEADDEAD, 2'b01);
        ld(3'b010, 32'h10, 32'hBEEFAA01, 2'b00);

        st(3'b010, 32'h0, 32'h11111111, 2'b00);
        ld(3'b010, 32'h1000, 32'h0, 2'b10);
        st(3'b010, 32'h1000, 32'hDEADBEEF, 2'b10);
        ld(3'b010, 32'h0, 32'h11111111, 2'b00);
        ld(3'b011, 32'h10, 32'h0, 2'b11);
        ld(3'b011, 32'h11, 32'h0, 2'b11);
        st(3'b100, 32'h10, 32'h0, 2'b11);
        ld(3'b110, 32'h10, 32'h0, 2'b11);
        ld(3'b010, 32'h10, 32'hBEEFAA01, 2'b00);

        st(3'b010, 32'hFFC, 32'hCAFEF00D, 2'b00);
        ld(3'b010, 32'hFFC, 32'hCAFEF00D, 2'b00);

        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            w    = {24'($urandom), b[i]};
            st(3'b000, 32'h40 + 32'(i), w, 2'b00);
        end
        ld(3'b010, 32'h40, {b[3], b[2], b[1], b[0]}, 2'b00);
        ld(3'b000, 32'h42, {{24{b[2][7]}}, b[2]}, 2'b00);
        ld(3'b101, 32'h42, {16'h0, b[3], b[2]}, 2'b00);

        resp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_rdata", resp_rdata, 32'hCAFEF00D);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_valid", 32'(resp_valid), 32'd0);

        resp_ready = 1'b0;
        issue(1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0, 1'b0, 2'b00, 1'b0);
        chk("pre_rst_valid", 32'(resp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        ld(3'b010, 32'h20, 32'h12345678, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter DWIDTH, default 32: data width in bits; the only legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 1024: number of DWIDTH-bit words; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V funct3 access size/sign.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  DWIDTH  store data, right-aligned.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  consumer accepts the response.
REQ-013 resp_rdata  output  DWIDTH  load result, extended to DWIDTH.
REQ-014 resp_err  output  1  access faulted.
REQ-015 resp_cause  output  2  fault cause: 00 none, 01 misaligned, 10 out-of-range, 11 illegal funct3.

Function
REQ-016 The block SHALL hold DEPTH x DWIDTH storage as little-endian byte lanes; B = DWIDTH/8; offset = req_addr[log2(B)-1:0]; index = req_addr[31:log2(B)].
REQ-017 The FSM SHALL have two states: IDLE and RESP; req_ready = 1 only in IDLE.
REQ-018 A request SHALL be accepted on a clock edge where req_valid && req_ready; the state then moves to RESP and resp_valid = 1 in the following cycle (1-cycle latency).
REQ-019 In RESP, outputs SHALL hold stable until resp_valid && resp_ready; on that edge the state returns to IDLE and resp_valid drops to 0.
REQ-020 Maximum throughput SHALL be one request per two cycles; no request is accepted in the cycle a response completes.
REQ-021 Loads: 000 LB and 001 LH SHALL sign-extend; 100 LBU and 101 LHU SHALL zero-extend; 010 LW SHALL pass through at DWIDTH=32 and sign-extend at DWIDTH=64.
REQ-022 Loads 110 LWU and 011 LD SHALL be legal only when DWIDTH=64.
REQ-023 Stores: 000 SB, 001 SH, 010 SW, and 011 SD (DWIDTH=64 only) SHALL write only the addressed byte lanes from the low bytes of req_wdata; other lanes are unchanged.
REQ-024 Any funct3 not listed for the given direction and DWIDTH SHALL be illegal.
REQ-025 Misaligned SHALL mean: halfword with addr[0] != 0, word with addr[1:0] != 0, or doubleword with addr[2:0] != 0.
REQ-026 Out-of-range SHALL mean index >= DEPTH.
REQ-027 Fault cause priority SHALL be illegal > misaligned > out-of-range.
REQ-028 A faulting request SHALL be accepted normally and SHALL NOT write memory; its response carries resp_err = 1, the cause, and resp_rdata = 0.
REQ-029 A store SHALL commit on its acceptance edge; its response has resp_rdata = 0, resp_err = 0, resp_cause = 00.
REQ-030 A load SHALL sample memory on its acceptance edge and return the registered, extended value.
REQ-031 A load to an address stored by the immediately preceding request SHALL return the new data.
REQ-032 resp_rdata, resp_err and resp_cause SHALL change only on an acceptance edge.

Reset
REQ-033 While rst_n = 0: state = IDLE, req_ready = 1 after release, resp_valid = 0, resp_rdata = 0, resp_err = 0, resp_cause = 00.
REQ-034 Memory contents SHALL NOT be reset.
REQ-035 Reset in RESP SHALL discard the pending response; a store already committed SHALL persist.

Verification
REQ-036 DWIDTH=32: SW addr 0x10 data 0x80FF7F01, then LB 0x10 -> 0x00000001; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x12 -> 0x000080FF.
REQ-037 SB 0x11 data 0xAA over word 0x80FF7F01, then LW 0x10 -> 0x80FFAA01.
REQ-038 LH 0x13 -> resp_err = 1, cause 01, rdata 0; SW 0x12 -> cause 01 and the word is unchanged.
REQ-039 DEPTH=1024, LW 0x1000 -> cause 10; funct3 011 at DWIDTH=32 -> cause 11; a request misaligned and illegal -> cause 11.
REQ-040 Hold resp_ready = 0 for 5 cycles after a load: resp_valid and data stay stable and req_ready = 0 throughout; handshake -> req_ready = 1 next cycle.
REQ-041 Assert rst_n = 0 while in RESP after SW 0x20 data 0x12345678: resp_valid drops immediately; after release, LW 0x20 -> 0x12345678.
